cdc_req_arbiter: RTL and testbench

Round-robin arbiter that shares one single-clock resource, such as a register-file port or command engine, between N requesters living in foreign clock domains. Each requester uses a two-phase toggle handshake. The block synchronises every request toggle into `clk`, picks one pending requester at a time, sequences the resource through a start/done handshake, and returns a per-requester acknowledge toggle. A watchdog bounds how long the resource may hold a grant.

---
 rtl/cdc_req_arbiter.sv | 105 ++++++++++
 tb/tb_cdc_req_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cdc_req_arbiter.sv
// rtl/cdc_req_arbiter.sv - round-robin arbiter for toggle-handshake requesters sharing one resource
module cdc_req_arbiter #(
   parameter int N       = 4,
   parameter int STAGES  = 2,
   parameter int TIMEOUT = 255,
   parameter int SW      = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req_tgl,
   output logic [N-1:0]  ack_tgl,
   output logic          start,
   output logic [SW-1:0] sel,
   input  logic          done,
   output logic          busy,
   output logic          timeout_err
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

   state_t          state;
   logic [N-1:0]    sync [STAGES];
   logic [N-1:0]    req_s;
   logic [N-1:0]    pending;
   logic [SW-1:0]   last;
   logic [SW-1:0]   winner;
   logic [CW-1:0]   cnt;
   logic            wd_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) sync[k] <= '0;
      end else begin
         sync[0] <= req_tgl;
         for (int k = 1; k < STAGES; k++) sync[k] <= sync[k-1];
      end
   end

   assign req_s   = sync[STAGES-1];
   assign pending = req_s ^ ack_tgl;

   // Search starts just after the last served index so every requester gets a turn.
   always_comb begin : rr_search
      int   j;
      logic found;
      j      = 0;
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= N; k++) begin
         j = int'(last) + k;
         if (j >= N) j = j - N;
         if (!found && pending[j]) begin
            found  = 1'b1;
            winner = SW'(j);
         end
      end
   end

   assign wd_hit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         ack_tgl     <= '0;
         start       <= 1'b0;
         sel         <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         last        <= SW'(N - 1);
         cnt         <= '0;
      end else begin
         start       <= 1'b0;
         timeout_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (|pending) begin
                  sel   <= winner;
                  cnt   <= '0;
                  start <= 1'b1;
                  busy  <= 1'b1;
                  state <= S_START;
               end
            end
            S_START: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
               // A done coinciding with the watchdog limit is a normal completion.
               if (done || wd_hit) begin
                  ack_tgl[sel] <= ~ack_tgl[sel];
                  last         <= sel;
                  busy         <= 1'b0;
                  timeout_err  <= ~done;
                  state        <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cdc_req_arbiter.sv
// tb/tb_cdc_req_arbiter.sv - directed scoreboard bench for cdc_req_arbiter
module tb_cdc_req_arbiter;

   localparam int N  = 4;
   localparam int SW = 2;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_tgl;
   logic [N-1:0]  ack_tgl;
   logic          start;
   logic [SW-1:0] sel;
   logic          done;
   logic          busy;
   logic          timeout_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int s0, s1, te_cyc;
   int exp_sel_q[$];

   cdc_req_arbiter #(.N(N), .STAGES(2), .TIMEOUT(T), .SW(SW)) dut (
      .clk(clk), .rst_n(rst_n), .req_tgl(req_tgl), .ack_tgl(ack_tgl),
      .start(start), .sel(sel), .done(done), .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every start must match the next grant the bench predicted.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && start === 1'b1) begin
         if (exp_sel_q.size() == 0) begin
            chk("unexpected_start", {30'd0, sel}, 32'hFFFF_FFFF);
         end else begin
            chk("grant_sel", {30'd0, sel}, exp_sel_q.pop_front());
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string tag);
      int k;
      k = 0;
      while (start !== 1'b1 && k < 40) begin
         tick(1);
         k++;
      end
      chk(tag, start, 1);
   endtask

   task automatic complete(input int d);
      tick(d);
      done = 1'b1;
      tick(1);
      done = 1'b0;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      req_tgl = '0;
      done    = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   initial begin
      rst_n   = 1'b0;
      req_tgl = '0;
      done    = 1'b0;
      tick(2);
      chk("rst_ack", ack_tgl, 0);
      chk("rst_start", start, 0);
      chk("rst_sel", sel, 0);
      chk("rst_busy", busy, 0);
      chk("rst_terr", timeout_err, 0);
      rst_n = 1'b1;
      tick(1);

      // single request on index 2
      exp_sel_q.push_back(2);
      req_tgl = 4'b0100;
      tick(3);
      chk("single_start", start, 1);
      chk("single_sel", sel, 2);
      chk("single_busy", busy, 1);
      complete(3);
      chk("single_ack", ack_tgl, 4'b0100);
      chk("single_idle", busy, 0);

      // simultaneous requests from reset: 0,1,2,3 three cycles apart
      do_reset();
      for (int i = 0; i < N; i++) exp_sel_q.push_back(i);
      req_tgl = 4'b1111;
      wait_start("sim_start0");
      s0 = cyc;
      for (int i = 1; i < N; i++) begin
         complete(1);
         wait_start("sim_start");
         chk("sim_gap", cyc - s0, 3);
         s0 = cyc;
      end
      complete(1);
      chk("sim_ack", ack_tgl, 4'b1111);
      chk("sim_idle", busy, 0);

      // fairness: serve 2, then 0 and 3 pending -> 3 before 0
      exp_sel_q.push_back(2);
      req_tgl = 4'b1011;
      wait_start("rr_start2");
      complete(1);
      exp_sel_q.push_back(3);
      exp_sel_q.push_back(0);
      req_tgl = 4'b0010;
      wait_start("rr_start3");
      complete(2);
      wait_start("rr_start0");
      complete(2);
      chk("rr_ack", ack_tgl, 4'b0010);

      // watchdog: no done, WAIT lasts T cycles
      exp_sel_q.push_back(1);
      req_tgl = 4'b0000;
      wait_start("wd_start");
      s1 = cyc;
      te_cyc = 0;
      for (int k = 0; k < 20 && te_cyc == 0; k++) begin
         tick(1);
         if (timeout_err === 1'b1) te_cyc = cyc;
      end
      chk("wd_terr_cycle", te_cyc - s1, T + 1);
      chk("wd_ack", ack_tgl, 4'b0000);
      chk("wd_busy", busy, 0);
      tick(1);
      chk("wd_terr_pulse", timeout_err, 0);

      // done on the T-th WAIT cycle is a normal completion
      exp_sel_q.push_back(1);
      req_tgl = 4'b0010;
      wait_start("wd2_start");
      complete(T);
      chk("wd2_terr", timeout_err, 0);
      chk("wd2_ack", ack_tgl, 4'b0010);
      tick(1);
      chk("wd2_terr_after", timeout_err, 0);

      // spurious done in IDLE and START
      done = 1'b1;
      tick(1);
      done = 1'b0;
      chk("sp_idle_ack", ack_tgl, 4'b0010);
      chk("sp_idle_busy", busy, 0);
      exp_sel_q.push_back(0);
      req_tgl = 4'b0011;
      wait_start("sp_start");
      done = 1'b1;
      tick(1);
      done = 1'b0;
      chk("sp_start_ack", ack_tgl, 4'b0010);
      chk("sp_start_busy", busy, 1);
      tick(2);
      chk("sp_wait_ack", ack_tgl, 4'b0010);
      complete(0);
      chk("sp_done_ack", ack_tgl, 4'b0011);

      // asynchronous reset during WAIT abandons the grant
      exp_sel_q.push_back(1);
      req_tgl = 4'b0001;
      wait_start("mr_start");
      tick(2);
      chk("mr_busy_before", busy, 1);
      rst_n   = 1'b0;
      req_tgl = '0;
      #1;
      chk("mr_ack", ack_tgl, 0);
      chk("mr_start", start, 0);
      chk("mr_sel", sel, 0);
      chk("mr_busy", busy, 0);
      chk("mr_terr", timeout_err, 0);
      tick(2);
      rst_n = 1'b1;
      tick(10);
      chk("mr_no_start", start, 0);
      chk("mr_idle", busy, 0);
      chk("queue_empty", exp_sel_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
